// File: rtl/exec_pkg.sv
// Shared types for the picoMIPS execution sequencer: FSM states, opcode classes
// and the opcode classifier built on the picoMIPS opcode macros.
`ifndef PM_OPCODES_SVH
`define PM_OPCODES_SVH
`define PM_OP_LIR   6'h01
`define PM_OP_ADD   6'h02
`define PM_OP_ADDI  6'h03
`define PM_OP_MUL   6'h04
`define PM_OP_MULI  6'h05
`define PM_OP_WAIT0 6'h06
`define PM_OP_WAIT1 6'h07
`define PM_OP_LSR   6'h08
`endif

package exec_pkg;

  localparam int unsigned OP_W = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_WAIT = 2'd2,
    SW_WAIT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    C_ALU   = 3'd0,
    C_MUL   = 3'd1,
    C_WAIT0 = 3'd2,
    C_WAIT1 = 3'd3,
    C_LSR   = 3'd4,
    C_BAD   = 3'd5
  } op_class_e;

  function automatic op_class_e classify(input logic [OP_W-1:0] op);
    op_class_e c;
    case (op)
      `PM_OP_LIR, `PM_OP_ADD, `PM_OP_ADDI: c = C_ALU;
      `PM_OP_MUL, `PM_OP_MULI:             c = C_MUL;
      `PM_OP_WAIT0:                        c = C_WAIT0;
      `PM_OP_WAIT1:                        c = C_WAIT1;
      `PM_OP_LSR:                          c = C_LSR;
      default:                             c = C_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stable-sample counter for one board switch;
// sw_clean flips only after DEB_CYCLES consecutive differing samples.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_clean
);

  localparam int unsigned CNT_W = 8;

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count only while the synchronised level disagrees with the clean level.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        clean_d = ~clean_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_clean = clean_q;

endmodule

// File: rtl/exec_sequencer.sv
// picoMIPS execution controller: sequences ALU, multi-cycle multiply and
// switch-wait instructions, driving PC advance and register write strobes.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DEB_CYCLES = 3,
  parameter int unsigned O_SIZE     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [O_SIZE-1:0] opcode,
  input  logic              sw8_raw,
  output logic              pc_en,
  output logic              reg_we,
  output logic              alu_start,
  output logic              sw8_clean,
  output logic              busy,
  output logic              illegal
);

  localparam int unsigned MUL_W = 4;

  state_e           state_q, state_d;
  logic [MUL_W-1:0] mul_cnt_q, mul_cnt_d;
  logic             illegal_q, illegal_d;
  op_class_e        op_class;
  logic             cond;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw8_debounce (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw8_raw),
    .sw_clean (sw8_clean)
  );

  assign op_class = classify(OP_W'(opcode));
  // Wait conditions read the registered clean level, so a same-cycle toggle is seen.
  assign cond     = (op_class == C_WAIT0) ? ~sw8_clean : sw8_clean;

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    illegal_d = illegal_q;
    pc_en     = 1'b0;
    reg_we    = 1'b0;
    alu_start = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: state_d = EXEC;
      EXEC: begin
        case (op_class)
          C_ALU: begin
            pc_en  = 1'b1;
            reg_we = 1'b1;
          end
          C_MUL: begin
            alu_start = 1'b1;
            if (MUL_CYCLES == 1) begin
              pc_en  = 1'b1;
              reg_we = 1'b1;
            end else begin
              mul_cnt_d = MUL_W'(MUL_CYCLES - 1);
              state_d   = MUL_WAIT;
            end
          end
          C_WAIT0, C_WAIT1, C_LSR: begin
            if (cond) begin
              pc_en  = 1'b1;
              reg_we = (op_class == C_LSR);
            end else begin
              state_d = SW_WAIT;
            end
          end
          default: begin
            illegal_d = 1'b1;
            pc_en     = 1'b1;
          end
        endcase
      end
      MUL_WAIT: begin
        busy      = 1'b1;
        mul_cnt_d = mul_cnt_q - MUL_W'(1);
        if (mul_cnt_q == MUL_W'(1)) begin
          pc_en   = 1'b1;
          reg_we  = 1'b1;
          state_d = EXEC;
        end
      end
      SW_WAIT: begin
        busy = 1'b1;
        if (cond) begin
          pc_en   = 1'b1;
          reg_we  = (op_class == C_LSR);
          state_d = EXEC;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are suppressed while reset is held so an aborted op never commits.
    if (reset) begin
      pc_en     = 1'b0;
      reg_we    = 1'b0;
      alu_start = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mul_cnt_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execution controller for the picoMIPS core. Sits between the instruction decoder's opcode field and the PC/register file.
- Sequences each instruction through single-cycle ALU ops, a multi-cycle multiply and switch-wait stalls.
- Drives PC increment and register write-enable.
- Owns the SW8 synchroniser/debouncer, so the datapath sees only a clean, stable switch level.

Parameters:
- MUL_CYCLES, 4, cycles the multiplier needs from alu_start to a valid result (legal range 1..15)
- DEB_CYCLES, 3, consecutive stable synchronised samples required before sw8_clean changes (legal range 1..255)
- O_SIZE, 6, opcode width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  O_SIZE  opcode of the current instruction (valid whenever state is EXEC)
- sw8_raw  in  1  asynchronous SW8 from the board
- pc_en  out  1  one-cycle pulse: PC advances at the next edge
- reg_we  out  1  one-cycle pulse: destination register writes at the next edge
- alu_start  out  1  one-cycle pulse launching a multiply
- sw8_clean  out  1  debounced SW8 level
- busy  out  1  high in MUL_WAIT or SW_WAIT
- illegal  out  1  sticky flag: an unimplemented opcode was executed

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, sync flops 0, debounce counter 0, mul counter 0. Reset mid-multiply or mid-wait aborts the operation: no pc_en/reg_we pulse is issued and the FSM returns to IDLE.
- SW8 synchroniser: 2 flops.
- Debouncer:
  - Counter clears whenever the synchronised level equals sw8_clean.
  - Otherwise it increments. On reaching DEB_CYCLES, sw8_clean toggles and the counter clears.
  - Latency from a clean sw8_raw edge to sw8_clean: 2+DEB_CYCLES cycles.
- IDLE: lasts one cycle after reset, outputs 0, then goes to EXEC.
- EXEC, by opcode class:
  - LIR, ADD, ADDI: reg_we=1, pc_en=1 combinationally; stay in EXEC.
  - MUL, MULI: alu_start=1, load mul counter with MUL_CYCLES-1, go to MUL_WAIT. If MUL_CYCLES=1, reg_we=pc_en=1 in the same cycle and stay in EXEC.
  - WAIT0 (cond = !sw8_clean), WAIT1 (cond = sw8_clean): if cond, pc_en=1 and stay; else go to SW_WAIT.
  - LSR (cond = sw8_clean): as WAIT1, but reg_we is asserted together with pc_en.
  - Other opcode: set illegal, pc_en=1 (treated as NOP).
- MUL_WAIT:
  - Decrement the counter each cycle; busy=1.
  - When the counter reaches 0: reg_we=1, pc_en=1, return to EXEC.
  - Total multiply: MUL_CYCLES cycles from alu_start to the write pulse, inclusive of the write cycle.
- SW_WAIT:
  - Opcode is held (PC frozen); busy=1.
  - Evaluate cond on sw8_clean every cycle. When true: pc_en=1 (plus reg_we for LSR), return to EXEC.
- Simultaneous sw8_clean toggle and cond evaluation: use the post-toggle (registered) value. cond reads the sw8_clean register output.
- pc_en and reg_we are never high for more than one cycle per instruction. alu_start never fires outside EXEC.
- Counter widths: mul counter 4 bits, debounce counter 8 bits; neither wraps, because both are cleared or reloaded before overflow.
- illegal is cleared only by reset.

Decomposition:
- Shared package exec_pkg: state enum (IDLE, EXEC, MUL_WAIT, SW_WAIT), an opcode-class enum (C_ALU, C_MUL, C_WAIT0, C_WAIT1, C_LSR, C_BAD), and a function classify(opcode) built on the codebase's existing opcode macros.
- Sub-module sw_debounce (synchroniser + DEB_CYCLES counter, output sw8_clean). It is reusable for further switches.

Test Plan:
- Reset, then opcode=ADD held → cycle 1 IDLE (pc_en=0); from cycle 2, pc_en=reg_we=1 every cycle, busy=0.
- MUL with MUL_CYCLES=4 → alu_start at cycle t; busy t+1..t+3; reg_we=pc_en=1 only at t+3; exactly one pulse of each.
- WAIT1 with sw8_raw=0 → stays in SW_WAIT, pc_en=0. Raise sw8_raw at cycle t → sw8_clean=1 at t+5 (DEB_CYCLES=3); pc_en pulse in that same cycle.
- Glitch: sw8_raw high for 2 cycles then low, during WAIT1 → sw8_clean stays 0, no pc_en.
- LSR with sw8_clean already 1 → reg_we=pc_en=1 in the first EXEC cycle, no stall. Opcode 6'h3F → illegal=1 and sticky; pc_en=1.
- Reset asserted at MUL_WAIT cycle 2 → next cycle state=IDLE, counter 0, no reg_we/pc_en pulse emitted.
